commit_rr: RTL and testbench

COMMIT_RR -- requirements
Module: commit_rr

---
 rtl/commit_rr.sv | 117 +++++++++++
 tb/tb_commit_rr.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_rr.sv
// rtl/commit_rr.sv - round-robin commit arbiter from execution-unit result channels onto register-file write ports
module commit_rr #(
    parameter int NUM_UNITS  = 5,
    parameter int NUM_WPORTS = 2,
    parameter int DATA_W     = 64,
    parameter int RN_W       = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_UNITS*DATA_W-1:0]    unit_result,
    input  logic [NUM_UNITS*RN_W-1:0]      unit_rn,
    input  logic [NUM_UNITS-1:0]           unit_valid,
    output logic [NUM_UNITS-1:0]           unit_stall,
    output logic [NUM_WPORTS*DATA_W-1:0]   write_data,
    output logic [NUM_WPORTS*RN_W-1:0]     write_rn,
    output logic [NUM_WPORTS-1:0]          write_en,
    output logic [NUM_WPORTS*RN_W-1:0]     finished_rn
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [DATA_W-1:0]           buf_data [NUM_UNITS];
    logic [RN_W-1:0]             buf_rn   [NUM_UNITS];
    logic [NUM_UNITS-1:0]        full;
    logic [PTR_W-1:0]            rr_ptr;

    logic [NUM_UNITS-1:0]        from_input;
    logic [NUM_UNITS-1:0]        cand;
    logic [NUM_UNITS-1:0]        grant;
    logic [DATA_W-1:0]           cand_data [NUM_UNITS];
    logic [RN_W-1:0]             cand_rn   [NUM_UNITS];

    logic [PTR_W-1:0]            nxt_ptr;
    logic [NUM_WPORTS-1:0]       nxt_en;
    logic [NUM_WPORTS*RN_W-1:0]  nxt_rn;
    logic [NUM_WPORTS*DATA_W-1:0] nxt_data;

    // A stalled unit's input is ignored; a buffered result always wins over the live input.
    always_comb begin
        from_input = '0;
        cand       = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            from_input[i] = unit_valid[i] & ~full[i] & (unit_rn[i*RN_W +: RN_W] != '0);
            cand[i]       = full[i] | from_input[i];
            cand_data[i]  = full[i] ? buf_data[i] : unit_result[i*DATA_W +: DATA_W];
            cand_rn[i]    = full[i] ? buf_rn[i]   : unit_rn[i*RN_W +: RN_W];
        end
    end

    // Scan from rr_ptr; a candidate whose rn is already being written this cycle waits,
    // which keeps same-register writes in scan order.
    always_comb begin
        int  n;
        int  idx;
        logic conflict;
        n        = 0;
        idx      = 0;
        conflict = 1'b0;
        grant    = '0;
        nxt_ptr  = rr_ptr;
        nxt_en   = '0;
        nxt_rn   = '0;
        nxt_data = '0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_UNITS)
                idx = idx - NUM_UNITS;
            if (cand[idx] && n < NUM_WPORTS) begin
                conflict = 1'b0;
                for (int k = 0; k < NUM_WPORTS; k++) begin
                    if (k < n && nxt_rn[k*RN_W +: RN_W] == cand_rn[idx])
                        conflict = 1'b1;
                end
                if (!conflict) begin
                    grant[idx]                  = 1'b1;
                    nxt_en[n]                   = 1'b1;
                    nxt_rn[n*RN_W +: RN_W]      = cand_rn[idx];
                    nxt_data[n*DATA_W +: DATA_W] = cand_data[idx];
                    nxt_ptr = (idx == NUM_UNITS - 1) ? '0 : PTR_W'(idx + 1);
                    n = n + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= '0;
            rr_ptr     <= '0;
            write_en   <= '0;
            write_rn   <= '0;
            write_data <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                buf_data[i] <= '0;
                buf_rn[i]   <= '0;
            end
        end else begin
            rr_ptr     <= nxt_ptr;
            write_en   <= nxt_en;
            write_rn   <= nxt_rn;
            write_data <= nxt_data;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (full[i] && grant[i]) begin
                    full[i] <= 1'b0;
                end else if (from_input[i] && !grant[i]) begin
                    full[i]     <= 1'b1;
                    buf_data[i] <= unit_result[i*DATA_W +: DATA_W];
                    buf_rn[i]   <= unit_rn[i*RN_W +: RN_W];
                end
            end
        end
    end

    assign unit_stall  = full;
    assign finished_rn = write_rn;

endmodule

// File: tb/tb_commit_rr.sv
// tb/tb_commit_rr.sv - scoreboard bench for commit_rr with directed vectors
module tb_commit_rr;

    localparam int NU = 5;
    localparam int NW = 2;
    localparam int DW = 64;
    localparam int RW = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NU*DW-1:0]   unit_result;
    logic [NU*RW-1:0]   unit_rn;
    logic [NU-1:0]      unit_valid;
    logic [NU-1:0]      unit_stall;
    logic [NW*DW-1:0]   write_data;
    logic [NW*RW-1:0]   write_rn;
    logic [NW-1:0]      write_en;
    logic [NW*RW-1:0]   finished_rn;

    commit_rr #(.NUM_UNITS(NU), .NUM_WPORTS(NW), .DATA_W(DW), .RN_W(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .unit_result (unit_result),
        .unit_rn     (unit_rn),
        .unit_valid  (unit_valid),
        .unit_stall  (unit_stall),
        .write_data  (write_data),
        .write_rn    (write_rn),
        .write_en    (write_en),
        .finished_rn (finished_rn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0]    en;
        logic [NW*RW-1:0] rn;
        logic [NW*DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] en, input logic [5:0] r0, input logic [63:0] d0,
                        input logic [5:0] r1, input logic [63:0] d1);
        exp_t e;
        e.en   = en;
        e.rn   = {r1, r0};
        e.data = {d1, d0};
        sb.push_back(e);
    endtask

    task automatic drive(input int u, input logic [5:0] rn, input logic [63:0] d);
        unit_valid[u]           = 1'b1;
        unit_rn[u*RW +: RW]     = rn;
        unit_result[u*DW +: DW] = d;
    endtask

    task automatic idle();
        unit_valid = '0;
    endtask

    function automatic logic [63:0] base(input int u);
        return 64'h1000 * 64'(u + 1);
    endfunction

    // Monitor: every cycle with a write must match the oldest expected entry.
    always @(negedge clk) begin
        if (write_en != '0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got en %b rn %h data %h expected none", write_en, write_rn, write_data);
            end else begin
                mon_e = sb.pop_front();
                check("write_en", 128'(write_en), 128'(mon_e.en));
                check("write_rn", 128'(write_rn), 128'(mon_e.rn));
                check("write_data", 128'(write_data), 128'(mon_e.data));
                check("finished_rn", 128'(finished_rn), 128'(mon_e.rn));
            end
            if (write_en == 2'b11)
                check("dup_rn", 128'(write_rn[RW-1:0] == write_rn[2*RW-1:RW]), 128'(0));
        end
    end

    // Hand-derived grant schedule for all-units-valid traffic starting at rr_ptr=0.
    int fa [10] = '{0, 2, 4, 1, 3, 0, 2, 4, 1, 3};
    int fb [10] = '{1, 3, 0, 2, 4, 1, 3, 0, 2, 4};
    int seq [NU];
    int cnt [NU];

    initial begin
        unit_valid  = '0;
        unit_rn     = '0;
        unit_result = '0;
        rst_n       = 1'b0;
        for (int i = 0; i < NU; i++) begin
            seq[i] = 0;
            cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_stall", 128'(unit_stall), 128'(0));
        check("rst_en", 128'(write_en), 128'(0));
        check("rst_rn", 128'(write_rn), 128'(0));
        check("rst_data", 128'(write_data), 128'(0));
        check("rst_fin", 128'(finished_rn), 128'(0));
        rst_n = 1'b1;

        // single result, first edge after release
        drive(0, 6'd5, 64'hAA);
        push(2'b01, 6'd5, 64'hAA, 6'd0, 64'd0);
        @(negedge clk);
        idle();
        check("single_stall", 128'(unit_stall), 128'(0));
        // unit 4 alone: pointer wraps back to 0
        drive(4, 6'd9, 64'h44);
        push(2'b01, 6'd9, 64'h44, 6'd0, 64'd0);
        @(negedge clk);
        idle();

        // over-subscription
        drive(0, 6'd1, 64'h11);
        drive(1, 6'd2, 64'h22);
        drive(2, 6'd3, 64'h33);
        push(2'b11, 6'd1, 64'h11, 6'd2, 64'h22);
        @(negedge clk);
        idle();
        check("oversub_stall1", 128'(unit_stall), 128'(5'b00100));
        push(2'b01, 6'd3, 64'h33, 6'd0, 64'd0);
        @(negedge clk);
        check("oversub_stall2", 128'(unit_stall), 128'(0));

        // same-rn conflict at rr_ptr=3
        drive(3, 6'd7, 64'h73);
        drive(4, 6'd7, 64'h74);
        push(2'b01, 6'd7, 64'h73, 6'd0, 64'd0);
        @(negedge clk);
        idle();
        check("conflict_stall1", 128'(unit_stall), 128'(5'b10000));
        push(2'b01, 6'd7, 64'h74, 6'd0, 64'd0);
        @(negedge clk);
        check("conflict_stall2", 128'(unit_stall), 128'(0));

        // rn=0 is discarded
        drive(1, 6'd0, 64'h55);
        @(negedge clk);
        idle();
        check("rn0_stall", 128'(unit_stall), 128'(0));

        // fairness: all units valid for 10 cycles; a stalled unit holds its result
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NU; i++) begin
                if (!unit_stall[i]) begin
                    drive(i, 6'(10 + i), base(i) + 64'(seq[i]));
                    seq[i]++;
                end
            end
            push(2'b11, 6'(10 + fa[c]), base(fa[c]) + 64'(cnt[fa[c]]),
                        6'(10 + fb[c]), base(fb[c]) + 64'(cnt[fb[c]]));
            cnt[fa[c]]++;
            cnt[fb[c]]++;
            @(negedge clk);
        end
        idle();
        check("fair_stall", 128'(unit_stall), 128'(5'b00111));
        push(2'b11, 6'd10, base(0) + 64'(cnt[0]), 6'd11, base(1) + 64'(cnt[1]));
        @(negedge clk);
        push(2'b01, 6'd12, base(2) + 64'(cnt[2]), 6'd0, 64'd0);
        @(negedge clk);
        check("fair_drain_stall", 128'(unit_stall), 128'(0));

        // reset mid-flight with buffers filling (rr_ptr=3)
        for (int i = 0; i < NU; i++)
            drive(i, 6'(20 + i), 64'h200 + 64'(i));
        push(2'b11, 6'd23, 64'h203, 6'd24, 64'h204);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        check("mid_rst_stall", 128'(unit_stall), 128'(0));
        check("mid_rst_en", 128'(write_en), 128'(0));
        check("mid_rst_rn", 128'(write_rn), 128'(0));
        check("mid_rst_data", 128'(write_data), 128'(0));
        check("mid_rst_fin", 128'(finished_rn), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_stall", 128'(unit_stall), 128'(0));
        drive(0, 6'd1, 64'h99);
        push(2'b01, 6'd1, 64'h99, 6'd0, 64'd0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
